// File: rtl/burst_pkg.sv
// burst_pkg: shared FSM state encodings for the burst register buffer
package burst_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/burst_fifo.sv
// burst_fifo: show-ahead word storage with pointers, level, full/empty and sticky overflow
module burst_fifo #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wen,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 ren,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level,
  output logic                 overflow
);
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok;
  assign wr_ok = wen && !full;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ren) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_ok) - (AW+1)'(ren);
      if (wen && full) overflow <= 1'b1;
    end
endmodule

// File: rtl/burst_reg_buf.sv
// burst_reg_buf: register buffer that streams a requested number of words per burst
module burst_reg_buf
  import burst_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wen,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 burst_start,
  input  logic [AW:0]          burst_len,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 burst_busy,
  output logic                 burst_done,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          level,
  output logic                 overflow
);
  state_t state, nxt;
  logic [AW:0] cnt;
  logic xfer;
  assign xfer = out_valid && out_ready;
  burst_fifo #(.BUS_WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .data_in(data_in), .ren(xfer),
    .data_out(data_out), .full(full), .empty(empty), .level(level), .overflow(overflow)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= clr ? IDLE : nxt;
  always_comb
    nxt = state == IDLE  ? (burst_start ? (burst_len == '0 ? DONE : BURST) : IDLE) :
          state == BURST ? (xfer && cnt == (AW+1)'(1) ? DONE : BURST) : IDLE;
  always_comb begin
    burst_busy = state == BURST;
    burst_done = state == DONE;
    out_valid = burst_busy && !empty;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (state == IDLE && burst_start) cnt <= burst_len;
    else if (state == BURST && xfer) cnt <= cnt - 1'b1;
endmodule

// File: tb/tb_burst_reg_buf.sv
// tb_burst_reg_buf: directed and random stimulus against a queue-based reference model
module tb_burst_reg_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic wen = 1'b0;
  logic [15:0] data_in = '0;
  logic burst_start = 1'b0;
  logic [3:0] burst_len = '0;
  logic out_ready = 1'b0;
  logic out_valid, burst_busy, burst_done, full, empty, overflow;
  logic [15:0] data_out;
  logic [3:0] level;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] q[$];
  bit ovf = 1'b0;
  int mode = 0;
  int rem = 0;

  burst_reg_buf dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .data_in(data_in),
    .burst_start(burst_start), .burst_len(burst_len), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .burst_busy(burst_busy),
    .burst_done(burst_done), .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wen = 0; burst_start = 0; out_ready = 0; clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", burst_busy, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    q.delete(); ovf = 0; mode = 0; rem = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cyc(input logic w, input logic [15:0] d, input logic bs, input logic [3:0] bl,
                     input logic rdy, input logic c);
    bit ev, wf;
    @(negedge clk);
    wen = w; data_in = d; burst_start = bs; burst_len = bl; out_ready = rdy; clr = c;
    #1;
    ev = (mode == 1) && (q.size() > 0);
    chk("out_valid", out_valid, ev);
    chk("burst_busy", burst_busy, mode == 1);
    chk("burst_done", burst_done, mode == 2);
    chk("level", level, q.size());
    chk("full", full, q.size() == 8);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, ovf);
    if (ev) chk("data_out", data_out, q[0]);
    if (c) begin
      q.delete(); ovf = 0; mode = 0;
    end else begin
      wf = q.size() == 8;
      if (mode == 0) begin
        if (bs) begin
          if (bl == 0) mode = 2;
          else begin mode = 1; rem = bl; end
        end
      end else if (mode == 1) begin
        if (ev && rdy) begin
          rem--;
          if (rem == 0) mode = 2;
        end
      end else mode = 0;
      if (ev && rdy) void'(q.pop_front());
      if (w) begin
        if (wf) ovf = 1;
        else q.push_back(d);
      end
    end
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 16'h0, 0, 4'd0, rdy, 0);
  endtask

  task automatic wr(input logic [15:0] d);
    cyc(1, d, 0, 4'd0, 0, 0);
  endtask

  initial begin
    do_reset();
    for (int i = 1; i <= 4; i++) wr(16'(i));
    cyc(0, 16'h0, 1, 4'd4, 1, 0);
    for (int i = 0; i < 6; i++) idle(1);
    chk("burst_level", level, 0);
    cyc(0, 16'h0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 9; i++) wr(16'h100 + 16'(i));
    idle(0);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 8);
    cyc(0, 16'h0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 8; i++) wr(16'h200 + 16'(i));
    cyc(0, 16'h0, 1, 4'd6, 1, 0);
    for (int i = 0; i < 8; i++) idle(1);
    for (int i = 0; i < 5; i++) wr(16'h300 + 16'(i));
    idle(0);
    chk("wrap_level", level, 7);
    cyc(0, 16'h0, 1, 4'd7, 1, 0);
    for (int i = 0; i < 9; i++) idle(1);
    wr(16'hA1);
    cyc(0, 16'h0, 1, 4'd3, 1, 0);
    for (int i = 0; i < 3; i++) idle(1);
    chk("stall_busy", burst_busy, 1);
    cyc(1, 16'hA2, 0, 4'd0, 1, 0);
    idle(1);
    idle(1);
    cyc(1, 16'hA3, 0, 4'd0, 1, 0);
    for (int i = 0; i < 3; i++) idle(1);
    cyc(0, 16'h0, 1, 4'd0, 1, 0);
    idle(1);
    chk("zero_done", burst_done, 1);
    chk("zero_level", level, 0);
    idle(1);
    wr(16'hB1);
    wr(16'hB2);
    cyc(0, 16'h0, 1, 4'd2, 1, 0);
    cyc(1, 16'hB3, 0, 4'd0, 1, 0);
    idle(0);
    chk("simul_level", level, 2);
    for (int i = 0; i < 3; i++) idle(1);
    wr(16'hC1);
    cyc(0, 16'h0, 1, 4'd4, 0, 0);
    idle(0);
    do_reset();
    idle(1);
    idle(1);
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom_range(1)), 16'($urandom), $urandom_range(5) == 0, 4'($urandom_range(8)),
          $urandom_range(3) != 0, $urandom_range(40) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
